// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch front end. Generates sequential fetch
//             addresses, drives a synchronous (one-cycle latency) instruction
//             SRAM, and buffers returned {instr, pc} pairs in a DEPTH-entry
//             circular queue that decode pops from. Absorbs decode stalls
//             without refetching and flushes stale work on a redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000,
    parameter int               PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,             // async, active-low
    output logic                       inst_sram_en,
    output logic [WIDTH-1:0]           inst_sram_addr,
    input  logic [WIDTH-1:0]           inst_sram_rdata,
    input  logic                       redirect_valid,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_instr,
    output logic [WIDTH-1:0]           deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int               c_PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               c_CW        = $clog2(DEPTH + 1);
    localparam int               c_CWX       = c_CW + 1;
    localparam logic [c_CWX-1:0] c_DEPTH_EXT = c_CWX'(DEPTH);
    localparam logic [WIDTH-1:0] c_STEP      = WIDTH'(PC_STEP);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Fetch side: next address to request and the single request in flight.
    logic [WIDTH-1:0] fpc_q,      fpc_d;
    logic             req_v_q,    req_v_d;
    logic [WIDTH-1:0] req_pc_q,   req_pc_d;
    logic             req_kill_q, req_kill_d;

    // Queue side: pointers wrap naturally because DEPTH is a power of two.
    logic [c_PW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [c_PW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [c_CW-1:0]  count_q,    count_d;

    // Entry storage carries no reset; count_q alone defines validity.
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic [c_CWX-1:0] w_occupancy;   // queued entries plus the one in flight
    logic             w_issue;
    logic             w_capture;
    logic             w_fire;

    // Reserve a slot for the outstanding request so the returning data always
    // has a home; only registered state feeds this, keeping deq_ready off the
    // SRAM enable path.
    assign w_occupancy = {1'b0, count_q} + {{c_CW{1'b0}}, req_v_q};
    assign w_issue     = rst & ~redirect_valid & (w_occupancy < c_DEPTH_EXT);

    // Data returned in a redirect cycle belongs to the old path and is dropped.
    assign w_capture   = req_v_q & ~req_kill_q & ~redirect_valid;

    assign deq_valid   = (count_q != '0);
    assign w_fire      = deq_valid & deq_ready;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign inst_sram_en   = w_issue;
    assign inst_sram_addr = fpc_q;
    assign deq_instr      = deq_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign deq_pc         = deq_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign count          = count_q;

    // Next-state for the fetch address and the in-flight request tracker.
    always_comb begin
        fpc_d      = fpc_q;
        req_v_d    = 1'b0;
        req_pc_d   = req_pc_q;
        req_kill_d = req_kill_q;
        if (redirect_valid) begin
            // Restart fetch at the target; anything outstanding is stale.
            fpc_d      = redirect_pc;
            req_kill_d = 1'b1;
        end else if (w_issue) begin
            fpc_d      = fpc_q + c_STEP;
            req_v_d    = 1'b1;
            req_pc_d   = fpc_q;
            req_kill_d = 1'b0;
        end
    end

    // Next-state for queue pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q + c_PW'(w_capture);
        rd_ptr_d = rd_ptr_q + c_PW'(w_fire);
        count_d  = count_q + c_CW'(w_capture) - c_CW'(w_fire);
        if (redirect_valid) begin
            // A firing head is simply consumed; everything behind it is
            // discarded by collapsing the read pointer onto the write pointer.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q      <= RESET_PC;
            req_v_q    <= 1'b0;
            req_pc_q   <= '0;
            req_kill_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fpc_q      <= fpc_d;
            req_v_q    <= req_v_d;
            req_pc_q   <= req_pc_d;
            req_kill_q <= req_kill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry write: store returned instruction alongside the PC that fetched it.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            instr_mem_q[wr_ptr_q] <= inst_sram_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue (DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = 32'hDEAD_BEEF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_instr;
    logic [31:0] deq_pc;
    logic [2:0]  count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pc;

    fetch_queue #(
        .WIDTH    (32),
        .DEPTH    (4),
        .RESET_PC (c_RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .deq_ready       (deq_ready),
        .deq_valid       (deq_valid),
        .deq_instr       (deq_instr),
        .deq_pc          (deq_pc),
        .count           (count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    // Synchronous SRAM: data for this cycle's request appears next cycle.
    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(deq_valid), 32'd1);
        check({tag, "_pc"},    deq_pc,         pc);
        check({tag, "_instr"}, deq_instr,      mem_word(pc));
    endtask

    // Advance to the next negative edge, apply inputs, let them settle.
    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        deq_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    // Startup sequence from a freshly released reset.
    task automatic startup(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        deq_ready = 1'b1;
        #1;
        check({tag, "_c1_en"},   32'(inst_sram_en), 32'd1);
        check({tag, "_c1_addr"}, inst_sram_addr,    c_RESET_PC);
        tick(1'b1, 1'b0, 32'h0);
        check({tag, "_c2_valid"}, 32'(deq_valid), 32'd0);
        check({tag, "_c2_addr"},  inst_sram_addr, c_RESET_PC + 32'd4);
        tick(1'b1, 1'b0, 32'h0);
        expect_head({tag, "_c3"}, c_RESET_PC);
        check({tag, "_c3_count"}, 32'(count), 32'd1);
    endtask

    initial begin
        rst            = 1'b0;
        deq_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_en",    32'(inst_sram_en), 32'd0);
        check("rst_valid", 32'(deq_valid),    32'd0);
        check("rst_count", 32'(count),        32'd0);
        check("rst_pc",    deq_pc,            32'd0);
        check("rst_instr", deq_instr,         32'd0);

        // ---------------- startup and streaming ----------------
        startup("boot");
        exp_pc = c_RESET_PC + 32'd4;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            expect_head("stream", exp_pc);
            check("stream_count", 32'(count), 32'd1);
            exp_pc += 32'd4;
        end

        // ---------------- decode stall: queue fills to 4 ----------------
        tick(1'b0, 1'b0, 32'h0);
        expect_head("stall0", exp_pc);
        check("stall0_count", 32'(count),        32'd1);
        check("stall0_en",    32'(inst_sram_en), 32'd1);
        tick(1'b0, 1'b0, 32'h0);
        check("stall1_count", 32'(count),        32'd2);
        check("stall1_en",    32'(inst_sram_en), 32'd1);
        tick(1'b0, 1'b0, 32'h0);
        check("stall2_count", 32'(count),        32'd3);
        check("stall2_en",    32'(inst_sram_en), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("stall3_count", 32'(count),        32'd4);
        check("stall3_en",    32'(inst_sram_en), 32'd0);
        repeat (6) tick(1'b0, 1'b0, 32'h0);
        check("stall9_count", 32'(count),        32'd4);
        check("stall9_en",    32'(inst_sram_en), 32'd0);
        expect_head("stall9", exp_pc);

        // ---------------- release: order preserved, no gap ----------------
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            expect_head("resume", exp_pc);
            exp_pc += 32'd4;
        end

        // ---------------- redirect with 3 queued, head firing ----------------
        tick(1'b0, 1'b0, 32'h0);
        check("pre_rd_count", 32'(count), 32'd2);
        expect_head("pre_rd", exp_pc);
        tick(1'b1, 1'b1, 32'h8000_0100);
        check("rd_t_count", 32'(count),        32'd3);
        check("rd_t_en",    32'(inst_sram_en), 32'd0);
        expect_head("rd_t", exp_pc);
        tick(1'b1, 1'b0, 32'h0);
        check("rd_t1_valid", 32'(deq_valid),    32'd0);
        check("rd_t1_count", 32'(count),        32'd0);
        check("rd_t1_en",    32'(inst_sram_en), 32'd1);
        check("rd_t1_addr",  inst_sram_addr,    32'h8000_0100);
        tick(1'b1, 1'b0, 32'h0);
        check("rd_t2_valid", 32'(deq_valid), 32'd0);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("rd_t3", 32'h8000_0100);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("rd_t4", 32'h8000_0104);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("rd_t5", 32'h8000_0108);

        // ---------------- back-to-back redirects ----------------
        tick(1'b1, 1'b1, 32'h0000_0100);
        expect_head("bb_u", 32'h8000_010C);
        check("bb_u_en", 32'(inst_sram_en), 32'd0);
        tick(1'b1, 1'b1, 32'h0000_0200);
        check("bb_u1_valid", 32'(deq_valid),    32'd0);
        check("bb_u1_en",    32'(inst_sram_en), 32'd0);
        tick(1'b1, 1'b0, 32'h0);
        check("bb_u2_valid", 32'(deq_valid),    32'd0);
        check("bb_u2_en",    32'(inst_sram_en), 32'd1);
        check("bb_u2_addr",  inst_sram_addr,    32'h0000_0200);
        tick(1'b1, 1'b0, 32'h0);
        check("bb_u3_valid", 32'(deq_valid), 32'd0);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("bb_u4", 32'h0000_0200);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("bb_u5", 32'h0000_0204);

        // ---------------- address wrap ----------------
        tick(1'b1, 1'b1, 32'hFFFF_FFF8);
        expect_head("wr_t", 32'h0000_0208);
        tick(1'b1, 1'b0, 32'h0);
        check("wr_t1_addr", inst_sram_addr, 32'hFFFF_FFF8);
        tick(1'b1, 1'b0, 32'h0);
        check("wr_t2_addr", inst_sram_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 32'h0);
        check("wr_t3_addr", inst_sram_addr,    32'h0000_0000);
        check("wr_t3_en",   32'(inst_sram_en), 32'd1);
        expect_head("wr_t3", 32'hFFFF_FFF8);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("wr_t4", 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("wr_t5", 32'h0000_0000);
        tick(1'b1, 1'b0, 32'h0);
        expect_head("wr_t6", 32'h0000_0004);

        // ---------------- reset mid-operation ----------------
        tick(1'b0, 1'b0, 32'h0);
        check("mr_a_count", 32'(count), 32'd1);
        tick(1'b0, 1'b0, 32'h0);
        check("mr_b_count", 32'(count), 32'd2);
        tick(1'b0, 1'b0, 32'h0);
        check("mr_c_count", 32'(count), 32'd3);
        expect_head("mr_c", 32'h0000_0008);
        rst = 1'b0;
        #1;
        check("mr_en",    32'(inst_sram_en), 32'd0);
        check("mr_valid", 32'(deq_valid),    32'd0);
        check("mr_count", 32'(count),        32'd0);
        check("mr_pc",    deq_pc,            32'd0);
        check("mr_instr", deq_instr,         32'd0);
        @(negedge clk);
        startup("reboot");
        tick(1'b1, 1'b0, 32'h0);
        expect_head("reboot_c4", c_RESET_PC + 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
